// File: rtl/uart_tx_engine.sv
// Buffered UART transmitter: valid/ready byte intake into a small FIFO, then
// start / 8 data (LSB first) / optional parity / 1-2 stop bits on RXD.
module uart_tx_engine #(
  parameter int unsigned CLOCK_HZ   = 100000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       Clock_100MHz,
  input  logic       Reset_n,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_Valid,
  output logic       Tx_Ready,
  output logic       RXD,
  output logic       Busy,
  output logic       Tx_Done,
  output logic [4:0] Fifo_Count
);

  localparam int unsigned DIV = CLOCK_HZ / BAUD;
  localparam int unsigned CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [4:0]    DEPTH_C   = 5'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          rxd_q, rxd_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic       push;
  logic       pop;
  logic       bit_end;
  logic [7:0] head;

  assign push    = Tx_Valid && ready_q;
  assign bit_end = (cnt_q == CNT_LAST);
  assign head    = mem_q[rd_ptr_q];

  // Next-state, FIFO bookkeeping and registered-output values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    pop      = 1'b0;
    rxd_d    = 1'b1;
    done_d   = 1'b0;
    busy_d   = 1'b0;
    ready_d  = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
            if (count_q != '0) pop = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Loading a new byte restarts bit timing; back-to-back frames skip IDLE
    if (pop) begin
      shift_d  = head;
      par_d    = ^head;
      cnt_d    = '0;
      bit_d    = '0;
      state_d  = S_START;
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    count_d = count_q + 5'(push) - 5'(pop);

    case (state_d)
      S_START:  rxd_d = 1'b0;
      S_DATA:   rxd_d = shift_d[0];
      S_PARITY: rxd_d = (PARITY == 1) ? ~par_d : par_d;
      default:  rxd_d = 1'b1;
    endcase

    done_d  = (state_d == S_STOP) && (cnt_d == CNT_LAST) && (bit_d == STOP_LAST);
    busy_d  = (state_d != S_IDLE) || (count_d != '0);
    ready_d = (count_d < DEPTH_C);
  end

  always_ff @(posedge Clock_100MHz) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      rxd_q    <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      rxd_q    <= rxd_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; writes are blocked while Reset_n is low
  always_ff @(posedge Clock_100MHz) begin
    if (Reset_n && push) mem_q[wr_ptr_q] <= Tx_Data;
  end

  assign Tx_Ready   = ready_q;
  assign RXD        = rxd_q;
  assign Busy       = busy_q;
  assign Tx_Done    = done_q;
  assign Fifo_Count = count_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: three instances (no parity/1 stop, even/1 stop,
// odd/2 stop) at DIV=4, with a per-cycle frame model fed by a byte scoreboard.
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic [2:0] vld;
  logic [2:0] rdy_w, rxd_w, busy_w, done_w;
  logic [4:0] cnt_w [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  uart_tx_engine #(.CLOCK_HZ(40), .BAUD(10), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8)) dut_a (
    .Clock_100MHz(clk), .Reset_n(rst_n), .Tx_Data(tx_data), .Tx_Valid(vld[0]),
    .Tx_Ready(rdy_w[0]), .RXD(rxd_w[0]), .Busy(busy_w[0]), .Tx_Done(done_w[0]),
    .Fifo_Count(cnt_w[0]));
  uart_tx_engine #(.CLOCK_HZ(40), .BAUD(10), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8)) dut_b (
    .Clock_100MHz(clk), .Reset_n(rst_n), .Tx_Data(tx_data), .Tx_Valid(vld[1]),
    .Tx_Ready(rdy_w[1]), .RXD(rxd_w[1]), .Busy(busy_w[1]), .Tx_Done(done_w[1]),
    .Fifo_Count(cnt_w[1]));
  uart_tx_engine #(.CLOCK_HZ(40), .BAUD(10), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(8)) dut_c (
    .Clock_100MHz(clk), .Reset_n(rst_n), .Tx_Data(tx_data), .Tx_Valid(vld[2]),
    .Tx_Ready(rdy_w[2]), .RXD(rxd_w[2]), .Busy(busy_w[2]), .Tx_Done(done_w[2]),
    .Fifo_Count(cnt_w[2]));

  localparam int BITLEN = 4;
  int par_cfg [3] = '{0, 2, 1};
  int stp_cfg [3] = '{1, 1, 2};

  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  logic [7:0] exp_q2 [$];

  // Monitor state per instance
  logic        act [3];
  int          k [3];
  int          flen [3];
  int          ferr [3];
  logic [11:0] frm [3];
  logic [7:0]  cap_data [3];
  logic        cap_par [3];
  logic [7:0]  last_data [3];
  logic        last_par [3];
  int          last_len [3];
  int          frames_done [3];
  int          done_t [3];
  int          prev_done_t [3];
  int          pushes [3];

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [11:0] mk_frame(input logic [7:0] b, input int p);
    logic [11:0] f;
    f = 12'hFFF;
    f[0] = 1'b0;
    f[8:1] = b;
    if (p == 2) f[9] = ^b;
    else if (p == 1) f[9] = ~(^b);
    return f;
  endfunction

  function automatic int qsize(input int d);
    if (d == 0) return exp_q0.size();
    if (d == 1) return exp_q1.size();
    return exp_q2.size();
  endfunction

  function automatic logic [7:0] qpop(input int d);
    if (d == 0) return exp_q0.pop_front();
    if (d == 1) return exp_q1.pop_front();
    return exp_q2.pop_front();
  endfunction

  // Scoreboard intake: record every accepted handshake
  initial begin
    for (int d = 0; d < 3; d++) pushes[d] = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n === 1'b1) begin
        if (vld[0] && rdy_w[0]) begin exp_q0.push_back(tx_data); pushes[0]++; end
        if (vld[1] && rdy_w[1]) begin exp_q1.push_back(tx_data); pushes[1]++; end
        if (vld[2] && rdy_w[2]) begin exp_q2.push_back(tx_data); pushes[2]++; end
      end
    end
  end

  // Line monitor: every cycle of a frame is compared with the model
  initial begin
    logic [7:0] b;
    int bi;
    for (int d = 0; d < 3; d++) begin
      act[d] = 1'b0; k[d] = 0; frames_done[d] = 0; done_t[d] = 0; prev_done_t[d] = 0;
      last_len[d] = 0; last_data[d] = '0; last_par[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rst_n !== 1'b1) begin
          act[d] = 1'b0;
        end else begin
          if (!act[d] && done_w[d] === 1'b1) chk($sformatf("spurious_done%0d", d), 32'(done_w[d]), 0);
          if (!act[d] && rxd_w[d] === 1'b0) begin
            if (qsize(d) == 0) begin
              chk($sformatf("unexpected_frame%0d", d), 32'(qsize(d)), 1);
            end else begin
              b = qpop(d);
              frm[d] = mk_frame(b, par_cfg[d]);
              flen[d] = (9 + ((par_cfg[d] != 0) ? 1 : 0) + stp_cfg[d]) * BITLEN;
              k[d] = 0; ferr[d] = 0; act[d] = 1'b1;
            end
          end
          if (act[d]) begin
            bi = k[d] / BITLEN;
            if (rxd_w[d] !== frm[d][bi]) ferr[d]++;
            if (done_w[d] !== ((k[d] == flen[d] - 1) ? 1'b1 : 1'b0)) ferr[d]++;
            if (k[d] % BITLEN == 2) begin
              if (bi >= 1 && bi <= 8) cap_data[d][bi-1] = rxd_w[d];
              if (bi == 9) cap_par[d] = rxd_w[d];
            end
            if (done_w[d] === 1'b1) last_len[d] = k[d] + 1;
            k[d]++;
            if (k[d] == flen[d]) begin
              chk($sformatf("frame%0d", d), 32'(ferr[d]), 0);
              act[d] = 1'b0;
              last_data[d] = cap_data[d];
              last_par[d] = cap_par[d];
              prev_done_t[d] = done_t[d];
              done_t[d] = cyc;
              frames_done[d]++;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input int d, input logic [7:0] b);
    int n;
    logic taken;
    n = 0;
    taken = 1'b0;
    tx_data = b;
    vld[d] = 1'b1;
    while (!taken && n < 200) begin
      taken = rdy_w[d];
      tick();
      n++;
    end
    vld[d] = 1'b0;
    if (!taken) chk("push_timeout", 32'(taken), 1);
  endtask

  task automatic wait_frames(input int d, input int n, input string name);
    int t;
    t = 0;
    while (frames_done[d] < n && t < 400) begin
      tick();
      t++;
    end
    chk(name, 32'(frames_done[d] >= n), 1);
  endtask

  typedef struct {
    int         d;
    logic [7:0] data;
    int         exp_len;
    logic       exp_par;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int fd;
    int t;
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd;
    int t;
    tbl[0] = '{0, 8'h55, 40, 1'b0};
    tbl[1] = '{0, 8'h00, 40, 1'b0};
    tbl[2] = '{1, 8'h07, 44, 1'b1};
    tbl[3] = '{1, 8'h55, 44, 1'b0};
    tbl[4] = '{2, 8'h55, 48, 1'b1};
    tbl[5] = '{2, 8'h80, 48, 1'b0};
    tbl[6] = '{1, 8'hFF, 44, 1'b0};

    // Reset held with valid asserted
    rst_n = 1'b0;
    vld = 3'b001;
    tx_data = 8'h11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rxd", 32'(rxd_w[0]), 1);
      chk("rst_ready", 32'(rdy_w[0]), 0);
      chk("rst_count", 32'(cnt_w[0]), 0);
      chk("rst_busy", 32'(busy_w[0]), 0);
      chk("rst_done", 32'(done_w[0]), 0);
    end
    rst_n = 1'b1;
    vld = 3'b000;
    tick();
    chk("ready_after_release", 32'(rdy_w[0]), 1);
    chk("count_after_release", 32'(cnt_w[0]), 0);
    repeat (5) tick();
    chk("idle_rxd", 32'(rxd_w[0]), 1);
    chk("nothing_sent", 32'(frames_done[0]), 0);

    // First-byte latency on an idle engine
    tx_data = 8'h55;
    vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    chk("lat_count_n", 32'(cnt_w[0]), 1);
    chk("lat_rxd_n", 32'(rxd_w[0]), 1);
    tick();
    chk("lat_rxd_n1", 32'(rxd_w[0]), 0);
    chk("lat_count_n1", 32'(cnt_w[0]), 0);
    chk("lat_busy_n1", 32'(busy_w[0]), 1);
    wait_frames(0, 1, "lat_frame");
    chk("lat_len", 32'(last_len[0]), 40);
    chk("lat_data", 32'(last_data[0]), 32'h55);
    chk("busy_falls", 32'(busy_w[0]), 0);

    // Table of single frames across the three configurations
    for (int i = 0; i < 7; i++) begin
      fd = frames_done[tbl[i].d];
      push_byte(tbl[i].d, tbl[i].data);
      wait_frames(tbl[i].d, fd + 1, $sformatf("vec%0d_frame", i));
      chk($sformatf("vec%0d_len", i), 32'(last_len[tbl[i].d]), 32'(tbl[i].exp_len));
      chk($sformatf("vec%0d_data", i), 32'(last_data[tbl[i].d]), 32'(tbl[i].data));
      if (par_cfg[tbl[i].d] != 0)
        chk($sformatf("vec%0d_par", i), 32'(last_par[tbl[i].d]), 32'(tbl[i].exp_par));
      repeat (3) tick();
    end

    // Back-to-back frames, no idle gap
    fd = frames_done[0];
    push_byte(0, 8'hA5);
    push_byte(0, 8'h3C);
    push_byte(0, 8'hFF);
    chk("b2b_count", 32'(cnt_w[0]), 2);
    for (int i = 0; i < 3; i++) begin
      wait_frames(0, fd + i + 1, $sformatf("b2b_frame%0d", i));
      if (i > 0) chk($sformatf("b2b_spacing%0d", i), 32'(done_t[0] - prev_done_t[0]), 40);
    end
    chk("b2b_last_data", 32'(last_data[0]), 32'hFF);
    repeat (3) tick();
    chk("b2b_drained", 32'(cnt_w[0]), 0);

    // FIFO saturation under continuous valid
    fd = frames_done[0];
    pushes[0] = 0;
    vld[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tx_data = 8'(8'h30 + i);
      tick();
    end
    vld[0] = 1'b0;
    chk("full_count", 32'(cnt_w[0]), 8);
    chk("full_ready", 32'(rdy_w[0]), 0);
    chk("full_accepted", 32'(pushes[0]), 9);
    wait_frames(0, fd + 9, "full_drain");
    chk("full_last_data", 32'(last_data[0]), 32'h38);
    chk("full_queue_empty", 32'(exp_q0.size()), 0);
    repeat (3) tick();

    // Reset during data bit 3 with bytes queued
    push_byte(0, 8'h11);
    push_byte(0, 8'h22);
    push_byte(0, 8'h33);
    push_byte(0, 8'h44);
    t = 0;
    while (!(act[0] && k[0] >= 17) && t < 200) begin
      tick();
      t++;
    end
    chk("mid_reached_bit3", 32'(act[0] && k[0] >= 17), 1);
    fd = frames_done[0];
    rst_n = 1'b0;
    tick();
    chk("mid_rxd", 32'(rxd_w[0]), 1);
    chk("mid_count", 32'(cnt_w[0]), 0);
    chk("mid_done", 32'(done_w[0]), 0);
    chk("mid_ready", 32'(rdy_w[0]), 0);
    exp_q0.delete();
    tick();
    rst_n = 1'b1;
    repeat (50) tick();
    chk("mid_no_frame", 32'(frames_done[0]), 32'(fd));
    chk("mid_idle_rxd", 32'(rxd_w[0]), 1);
    push_byte(0, 8'h81);
    wait_frames(0, fd + 1, "post_reset_frame");
    chk("post_reset_data", 32'(last_data[0]), 32'h81);
    chk("post_reset_len", 32'(last_len[0]), 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
